multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state codes, opcode/funct constants and ALU codes for the multicycle controller
//
// Purpose: single source of truth for encodings used by multicycle_controller
//          and alu_decoder.
// Ports:   none (package).

package mc_pkg;

    // Controller state codes; 12-15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type funct to ALU operation decoder
//
// Purpose: maps an R-type funct field to the ALU operation code and flags
//          funct values the datapath does not support.
// Ports:
//   funct   in  6  instruction[5:0]
//   alu_op  out 3  decoded ALU operation (ALU_ADD when not valid)
//   valid   out 1  1 = funct is a supported R-type operation

import mc_pkg::*;

module alu_decoder (
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM
//
// Purpose: sequences FETCH/DECODE/execute/writeback for R-type, lw, sw, beq,
//          j and addi; counts retired instructions and flags illegal encodings.
// Ports:
//   clk, rst            clock, async active-high reset
//   opcode, funct       instruction fields from IR
//   zero                comparator equality result
//   mem_ready           memory access completes this cycle
//   pc_write..pc_src    datapath controls (Moore, pc_write/ir_write also
//                       qualified by mem_ready/zero)
//   state               current state code
//   instr_count         retired-instruction count
//   illegal             sticky unsupported-instruction flag

import mc_pkg::*;

module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [3:0]  state,
    output logic [31:0] instr_count,
    output logic        illegal
);

    state_t      r_state;
    logic [31:0] r_instr_count;
    logic        r_illegal;
    logic [2:0]  r_rtype_op;     // R-type ALU op captured in DECODE for R_EX

    logic [2:0]  w_fn_alu_op;
    logic        w_fn_valid;

    alu_decoder u_alu_decoder (
        .funct  (funct),
        .alu_op (w_fn_alu_op),
        .valid  (w_fn_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_instr_count <= 32'd0;
            r_illegal     <= 1'b0;
            r_rtype_op    <= ALU_ADD;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_rtype_op <= w_fn_alu_op;
                    case (opcode)
                        OP_RTYPE: begin
                            if (w_fn_valid) begin
                                r_state <= S_R_EX;
                            end else begin
                                r_state   <= S_FETCH;
                                r_illegal <= 1'b1;
                            end
                        end
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDI_EX;
                        default: begin
                            r_state   <= S_FETCH;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    // Only lw/sw reach here; opcode is stable in IR.
                    r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    if (mem_ready) r_state <= S_MEM_WB;
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        r_state       <= S_FETCH;
                        r_instr_count <= r_instr_count + 32'd1;
                    end
                end
                S_R_EX:    r_state <= S_R_WB;
                S_ADDI_EX: r_state <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 32'd1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of datapath controls; pc_write/ir_write are suppressed
    // while rst is high because r_state already reads FETCH.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready & ~rst;
                pc_write  = mem_ready & ~rst;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SL;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EX: begin
                alu_src_a = 1'b1;
                alu_op    = r_rtype_op;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero & ~rst;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = ~rst;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;
    assign illegal     = r_illegal;

endmodule
